// File: rtl/button_ctrl.sv
// ---------------------------------------------------------------------------
// button_ctrl -- start/speed key front end for the LED sequencer.
//
// Each raw mechanical key goes through a 2-flop synchronizer and an
// independent debounce FSM. A level change is accepted only after the
// synchronized key has been stable for DEBOUNCE_CNT cycles. An accepted
// start press pulses `button` and latches `running`. An accepted speed
// press advances `freq_set` modulo 4 in the same cycle.
//
// Ports
//   clk        in   system clock; all logic on its rising edge
//   rst        in   synchronous, active-high reset
//   key_start  in   raw start key (asynchronous, bouncy, active-high)
//   key_speed  in   raw speed key (asynchronous, bouncy, active-high)
//   button     out  one-cycle start pulse
//   freq_set   out  speed select, 00 fastest .. 11 slowest
//   running    out  high from the first accepted start press until rst
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// button_debounce -- synchronizer plus debounce FSM for one key.
//
// Ports
//   clk           in   system clock
//   rst           in   synchronous, active-high reset
//   i_key         in   raw asynchronous key
//   o_accept_set  out  high for exactly one cycle, on the edge where the FSM
//                      moves PRESS_WAIT -> PRESSED. The parent registers it,
//                      so the pulse is visible while the FSM sits in PRESSED
//                      for the first time.
// ---------------------------------------------------------------------------
module button_debounce #(
    parameter int unsigned DEBOUNCE_CNT = 2000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key,
    output logic o_accept_set
);

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    // The counter counts from 0 up to this value and never beyond, so it
    // cannot wrap. Entering a WAIT state uses one stable sample. This value
    // adds the remaining DEBOUNCE_CNT samples needed before the change is
    // accepted.
    localparam logic [23:0] CNT_LAST = 24'(DEBOUNCE_CNT - 1);

    logic        r_sync1;
    logic        r_sync2;
    logic [1:0]  r_state;
    logic [23:0] r_cnt;

    logic [1:0]  w_state_next;
    logic [23:0] w_cnt_next;
    logic        w_accept_set;
    logic        w_cnt_last;

    assign w_cnt_last = (r_cnt == CNT_LAST);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept_set = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_sync2) begin
                    w_state_next = ST_PRESS_WAIT;
                    w_cnt_next   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!r_sync2) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else if (w_cnt_last) begin
                    w_state_next = ST_PRESSED;
                    w_cnt_next   = '0;
                    w_accept_set = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 24'd1;
                end
            end
            ST_PRESSED: begin
                if (!r_sync2) begin
                    w_state_next = ST_RELEASE_WAIT;
                    w_cnt_next   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (r_sync2) begin
                    w_state_next = ST_PRESSED;
                    w_cnt_next   = '0;
                end else if (w_cnt_last) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 24'd1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments. Every flop
        // then samples pre-edge values, which makes the synchronizer a true
        // two-stage pipeline.
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    assign o_accept_set = w_accept_set;

endmodule

module button_ctrl #(
    parameter int unsigned DEBOUNCE_CNT = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start,
    input  logic       key_speed,
    output logic       button,
    output logic [1:0] freq_set,
    output logic       running
);

    logic       w_start_set;
    logic       w_speed_set;

    logic       r_button;
    logic       r_running;
    logic [1:0] r_freq;

    button_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_start_db (
        .clk          (clk),
        .rst          (rst),
        .i_key        (key_start),
        .o_accept_set (w_start_set)
    );

    button_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_speed_db (
        .clk          (clk),
        .rst          (rst),
        .i_key        (key_speed),
        .o_accept_set (w_speed_set)
    );

    // All three outputs update on the same edge from the two strobes.
    // A start and a speed accept in the same cycle therefore both take
    // effect, and the freq_set change lines up with the accept pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_button  <= 1'b0;
            r_running <= 1'b0;
            r_freq    <= 2'b00;
        end else begin
            r_button <= w_start_set;
            if (w_start_set) begin
                r_running <= 1'b1;
            end
            if (w_speed_set) begin
                r_freq <= r_freq + 2'd1;
            end
        end
    end

    assign button   = r_button;
    assign running  = r_running;
    assign freq_set = r_freq;

endmodule

// File: tb/tb_button_ctrl.sv
// ---------------------------------------------------------------------------
// tb_button_ctrl -- self-checking bench for button_ctrl with DEBOUNCE_CNT=4.
//
// Reference model: each key is a delayed sample stream. Its accepted level
// flips once DEBOUNCE_CNT+1 consecutive synchronized samples disagree with
// it, and a rising flip is an accept. Outputs are compared every cycle,
// 1 ns after the rising edge. Directed scenarios add tallies with fixed
// expectations.
// ---------------------------------------------------------------------------
module tb_button_ctrl;

    localparam int D = 4;

    logic       clk;
    logic       rst;
    logic       key_start;
    logic       key_speed;
    logic       button;
    logic [1:0] freq_set;
    logic       running;

    button_ctrl #(.DEBOUNCE_CNT(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_start (key_start),
        .key_speed (key_speed),
        .button    (button),
        .freq_set  (freq_set),
        .running   (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    bit   dly1 [2];
    bit   dly2 [2];
    bit   acc  [2];
    int   run  [2];
    bit   m_button;
    bit   m_running;
    bit [1:0] m_freq;

    // Scenario tallies, taken from observed outputs.
    int       step_idx;
    int       n_button;
    int       n_freq_chg;
    int       first_button_idx;
    int       first_freq_idx;
    logic [1:0] prev_freq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Feed one synchronized sample into a key model.
    // Returns 1 when the accepted level rises.
    function automatic bit key_advance(input int k, input bit synced);
        if (synced != acc[k]) run[k]++;
        else                  run[k] = 0;
        if (run[k] == D + 1) begin
            acc[k] = synced;
            run[k] = 0;
            return synced;
        end
        return 1'b0;
    endfunction

    task automatic model_edge();
        bit raw [2];
        bit syn [2];
        bit acc_hit [2];
        raw[0] = key_start;
        raw[1] = key_speed;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                dly1[k] = 0; dly2[k] = 0; acc[k] = 0; run[k] = 0;
            end
            m_button = 0; m_running = 0; m_freq = 2'b00;
        end else begin
            for (int k = 0; k < 2; k++) begin
                syn[k]     = dly2[k];
                dly2[k]    = dly1[k];
                dly1[k]    = raw[k];
                acc_hit[k] = key_advance(k, syn[k]);
            end
            m_button = acc_hit[0];
            if (acc_hit[0]) m_running = 1;
            if (acc_hit[1]) m_freq = m_freq + 2'd1;
        end
    endtask

    task automatic clear_tally();
        step_idx = 0; n_button = 0; n_freq_chg = 0;
        first_button_idx = -1; first_freq_idx = -1;
        prev_freq = freq_set;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        step_idx++;
        chk("button",   {31'd0, button},   {31'd0, m_button});
        chk("running",  {31'd0, running},  {31'd0, m_running});
        chk("freq_set", {30'd0, freq_set}, {30'd0, m_freq});
        if (button === 1'b1) begin
            n_button++;
            if (first_button_idx < 0) first_button_idx = step_idx;
        end
        if (freq_set !== prev_freq) begin
            n_freq_chg++;
            if (first_freq_idx < 0) first_freq_idx = step_idx;
        end
        prev_freq = freq_set;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int hs;
        int hp;
        rst = 1'b1; key_start = 1'b0; key_speed = 1'b0;
        for (int k = 0; k < 2; k++) begin
            dly1[k] = 0; dly2[k] = 0; acc[k] = 0; run[k] = 0;
        end
        m_button = 0; m_running = 0; m_freq = 2'b00;

        // Reset state.
        steps(3);
        chk("reset_button",   {31'd0, button},   32'd0);
        chk("reset_running",  {31'd0, running},  32'd0);
        chk("reset_freq_set", {30'd0, freq_set}, 32'd0);
        rst = 1'b0;

        // Start key raised and held: pulse in the cycle after edge N+D+2.
        steps(9);
        key_start = 1'b1;
        clear_tally();
        steps(20);
        chk("start_pulse_count", n_button, 1);
        chk("start_pulse_index", first_button_idx, D + 3);
        chk("start_running",     {31'd0, running},  32'd1);
        chk("start_freq_stays",  {30'd0, freq_set}, 32'd0);
        // A second press still pulses button while running is high.
        key_start = 1'b0;
        steps(10);
        key_start = 1'b1;
        clear_tally();
        steps(12);
        chk("repress_pulse_count", n_button, 1);
        key_start = 1'b0;
        steps(10);

        // Short press plus bounces: never accepted.
        do_reset();
        clear_tally();
        key_start = 1'b1; steps(3);
        key_start = 1'b0; steps(2);
        for (int b = 0; b < 5; b++) begin
            key_start = 1'b1; steps($urandom_range(1, 2));
            key_start = 1'b0; steps($urandom_range(1, 2));
        end
        steps(12);
        chk("bounce_no_pulse",   n_button, 0);
        chk("bounce_no_running", {31'd0, running}, 32'd0);

        // Four clean speed presses: 01, 10, 11, 00.
        do_reset();
        clear_tally();
        for (int p = 0; p < 4; p++) begin
            key_speed = 1'b1; steps(8);
            key_speed = 1'b0; steps(8);
        end
        chk("speed_changes",    n_freq_chg, 4);
        chk("speed_wrap_final", {30'd0, freq_set}, 32'd0);

        // Long hold with a short low glitch: a single increment.
        do_reset();
        clear_tally();
        key_speed = 1'b1; steps(50);
        key_speed = 1'b0; steps(2);
        key_speed = 1'b1; steps(48);
        key_speed = 1'b0; steps(10);
        chk("glitch_one_increment", n_freq_chg, 1);
        chk("glitch_freq_value",    {30'd0, freq_set}, 32'd1);

        // Both keys raised together: same-cycle effect.
        do_reset();
        key_start = 1'b1; key_speed = 1'b1;
        clear_tally();
        steps(15);
        chk("both_button_index", first_button_idx, D + 3);
        chk("both_freq_index",   first_freq_idx,   D + 3);
        chk("both_freq_count",   n_freq_chg, 1);
        key_start = 1'b0; key_speed = 1'b0;
        steps(10);

        // Reset during PRESS_WAIT with the key held: progress discarded.
        do_reset();
        steps(3);
        key_start = 1'b1;
        clear_tally();
        steps(4);
        chk("prereset_no_pulse", n_button, 0);
        clear_tally();
        rst = 1'b1;
        step();
        rst = 1'b0;
        steps(15);
        chk("postreset_pulse_count", n_button, 1);
        chk("postreset_pulse_index", first_button_idx, D + 4);
        key_start = 1'b0;
        steps(10);

        // Randomized keys with occasional reset, against the model.
        hs = 1; hp = 1;
        for (int i = 0; i < 800; i++) begin
            if (--hs == 0) begin
                key_start = 1'($urandom_range(0, 1));
                hs = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 14) : $urandom_range(1, 6);
            end
            if (--hp == 0) begin
                key_speed = 1'($urandom_range(0, 1));
                hp = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 14) : $urandom_range(1, 6);
            end
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_ctrl.md
BUTTON_CTRL -- requirements
Module: button_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CNT, default 2000000, is the number of consecutive stable synchronized cycles required to accept a level change (20 ms at 100 MHz); legal range 2..2^24-1.
REQ-002 clk  input  1  single system clock; all logic on posedge clk.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 key_start  input  1  raw mechanical start key, asynchronous, active-high, bouncy.
REQ-005 key_speed  input  1  raw mechanical speed key, asynchronous, active-high, bouncy.
REQ-006 button  output  1  one-cycle start pulse to the LED sequencer.
REQ-007 freq_set  output  2  speed select to the LED sequencer (00 fastest .. 11 slowest).
REQ-008 running  output  1  level; high once a start press has been accepted.

Function
REQ-009 Each key SHALL pass through its own 2-flip-flop synchronizer; no other logic SHALL sample key_start or key_speed directly.
REQ-010 Each key SHALL have an independent debounce FSM with states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT, plus a 24-bit stable counter.
REQ-011 IDLE: synchronized key high -> PRESS_WAIT, counter cleared to 0.
REQ-012 PRESS_WAIT: key high -> counter +1; key low -> back to IDLE, counter 0; counter reaching DEBOUNCE_CNT-1 while key high -> PRESSED.
REQ-013 The transition PRESS_WAIT->PRESSED SHALL produce exactly one one-cycle accept pulse for that key, registered, in the cycle the FSM is in PRESSED for the first time.
REQ-014 PRESSED: key low -> RELEASE_WAIT, counter 0; key high -> stay; no further pulses however long the key is held.
REQ-015 RELEASE_WAIT: key low -> counter +1; key high -> back to PRESSED, counter 0; counter reaching DEBOUNCE_CNT-1 while key low -> IDLE.
REQ-016 Latency: with the raw key held high from the clock edge that first samples it high (edge N), the accept pulse SHALL be high in the cycle after edge N+DEBOUNCE_CNT+2, and SHALL be identical (+/-0 cycles) for both keys.
REQ-017 Any high glitch shorter than DEBOUNCE_CNT synchronized cycles SHALL produce no pulse; any low glitch shorter than DEBOUNCE_CNT during PRESSED SHALL not allow a second pulse.
REQ-018 button SHALL equal the start-key accept pulse (every accepted start press pulses button, including when running is already 1).
REQ-019 running SHALL set to 1 on the first start accept pulse and hold until rst.
REQ-020 On each speed-key accept pulse freq_set SHALL increment by 1 modulo 4 (11 wraps to 00), updating in the same cycle as the pulse.
REQ-021 Simultaneous start and speed accept pulses SHALL both take effect in the same cycle; neither has priority.
REQ-022 The stable counter SHALL never exceed DEBOUNCE_CNT-1 and SHALL not wrap.

Reset
REQ-023 While rst is high at a clock edge: both FSMs -> IDLE, counters 0, synchronizer flops 0, button 0, running 0, freq_set 00.
REQ-024 Reset asserted mid-debounce or while PRESSED SHALL discard progress; after release a key already held high SHALL be re-debounced from IDLE and SHALL produce one pulse after the full REQ-016 latency.
REQ-025 No output SHALL change asynchronously to clk.

Verification (DEBOUNCE_CNT=4)
REQ-026 key_start raised at edge 10 and held -> button high exactly for the cycle after edge 16, running 1 from then on, freq_set stays 00.
REQ-027 key_start pulses high for 3 cycles, then 5 bounces of 1-2 cycles -> button never asserted, running stays 0.
REQ-028 Four clean key_speed presses (8 cycles high, 8 low each) -> freq_set 01, 10, 11, 00, each change exactly one cycle-aligned with its accept pulse.
REQ-029 key_speed held high for 100 cycles with a 2-cycle low glitch at cycle 50 -> exactly one increment.
REQ-030 key_start and key_speed raised on the same edge -> button pulse and freq_set increment in the same cycle.
REQ-031 rst asserted for 1 cycle while key_start in PRESS_WAIT, key held -> no pulse before reset, one pulse DEBOUNCE_CNT+2 cycles after reset release.
